cordic_request_sequencer: RTL and testbench

Initiator-side sequencer for the variable-latency CORDIC cosine unit. It accepts FP32 angles on a valid/ready stream, issues each one to the cosine unit over its custom-instruction port (`clk_en`/`start`/`dataa` → `result`/`done`), and gates `clk_en` so the unit freezes once its result is ready. Each result, with an error flag, goes into a small output FIFO. It sits between a DMA/stream front end and one cosine unit, replacing the Nios II custom-instruction master when angles are processed in batches.

---
 rtl/cordic_seq_pkg.sv | 19 +
 rtl/cordic_result_fifo.sv | 59 +++++
 rtl/cordic_request_sequencer.sv | 100 ++++++++++
 tb/tb_cordic_request_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_seq_pkg.sv
// Shared types and defaults for the CORDIC request sequencer.
package cordic_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } seq_state_t;

   // One result slot: error flag plus the FP32 cosine word.
   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } fifo_entry_t;

   localparam int DEF_OUT_DEPTH      = 4;
   localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/cordic_result_fifo.sv
// First-word fall-through result FIFO; head word reads as zero when empty.
module cordic_result_fifo
   import cordic_seq_pkg::*;
#(
   parameter int DEPTH = DEF_OUT_DEPTH
) (
   input  logic        clock,
   input  logic        aclr_n,
   input  logic        push,
   input  logic        push_err,
   input  logic [31:0] push_data,
   input  logic        pop,
   output logic        full,
   output logic        empty,
   output logic        head_err,
   output logic [31:0] head_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   fifo_entry_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   // Gating with empty keeps the outputs low after reset without clearing storage.
   assign head_err  = !empty && mem[rd_ptr].err;
   assign head_data = empty ? '0 : mem[rd_ptr].data;

   // Storage write; contents are don't-care until counted in.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= '{err: push_err, data: push_data};
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cordic_request_sequencer.sv
// Issues stream angles one at a time to the CORDIC cosine unit and queues results.
module cordic_request_sequencer
   import cordic_seq_pkg::*;
#(
   parameter int OUT_DEPTH      = DEF_OUT_DEPTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic        clock,
   input  logic        aclr_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_err,
   output logic        cordic_clk_en,
   output logic        cordic_start,
   output logic [31:0] cordic_dataa,
   input  logic [31:0] cordic_result,
   input  logic        cordic_done,
   output logic        busy,
   output logic [7:0]  err_count
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Counter value seen during the TIMEOUT_CYCLES-th WAIT cycle.
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   seq_state_t    state;
   logic [CW-1:0] wait_cnt;
   logic          run_q;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          push_err;
   logic [31:0]   push_data;

   // run_q holds in_ready low until the first edge after reset release.
   assign in_ready      = run_q && (state == IDLE) && !fifo_full;
   assign busy          = (state != IDLE);
   assign cordic_start  = (state == ISSUE);
   // Done is combinational from the unit, so freezing it must be too.
   assign cordic_clk_en = (state == ISSUE) || ((state == WAIT) && !cordic_done);
   // Done beats a coincident timeout.
   assign push          = (state == WAIT) && (cordic_done || (wait_cnt == TMO_LAST));
   assign push_err      = !cordic_done;
   assign push_data     = cordic_done ? cordic_result : '0;
   assign out_valid     = !fifo_empty;

   // Sequencer FSM, timeout counter and error counter.
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         cordic_dataa <= '0;
         err_count    <= '0;
         run_q        <= 1'b0;
      end else begin
         run_q <= 1'b1;
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  cordic_dataa <= in_data;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (cordic_done) begin
                  state <= IDLE;
               end else if (wait_cnt == TMO_LAST) begin
                  state <= IDLE;
                  if (err_count != 8'hFF) err_count <= err_count + 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   cordic_result_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
      .clock     (clock),
      .aclr_n    (aclr_n),
      .push      (push),
      .push_err  (push_err),
      .push_data (push_data),
      .pop       (out_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_err  (out_err),
      .head_data (out_data)
   );

endmodule

// File: tb/tb_cordic_request_sequencer.sv
// Self-checking bench: behavioural cosine-unit stand-in, table vectors,
// corner sequences and a randomized scoreboard run.
module tb_cordic_request_sequencer;
   import cordic_seq_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic        clock = 1'b0;
   logic        aclr_n = 1'b0;
   logic        in_valid, in_ready, out_valid, out_ready, out_err;
   logic [31:0] in_data, out_data;
   logic        cordic_clk_en, cordic_start, cordic_done, busy;
   logic [31:0] cordic_dataa, cordic_result;
   logic [7:0]  err_count;

   int total = 0;
   int bad   = 0;

   cordic_request_sequencer #(.OUT_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .aclr_n(aclr_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .cordic_clk_en(cordic_clk_en), .cordic_start(cordic_start), .cordic_dataa(cordic_dataa),
      .cordic_result(cordic_result), .cordic_done(cordic_done),
      .busy(busy), .err_count(err_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Cosine values for a few known angles, a scrambled word otherwise.
   function automatic logic [31:0] cos_ref(input logic [31:0] a);
      case (a)
         32'h3F800000: return 32'h3F0A5140;
         32'h00000000: return 32'h3F800000;
         32'h3F000000: return 32'h3F60A8B2;
         32'h3FC00000: return 32'h3D90DEAA;
         32'h40490FDB: return 32'hBF800000;
         default:      return {a[15:0], a[31:16]} ^ 32'hC0DEC0DE;
      endcase
   endfunction

   // Unit stand-in: done after cfg_lat enabled iterations, holds while frozen.
   int          cfg_lat = 4;
   bit          cfg_nd  = 1'b0;
   int          m_it = 0, m_lat = 0;
   bit          m_nd = 1'b1;
   logic [31:0] m_a  = '0;
   always @(posedge clock) begin
      if (cordic_clk_en) begin
         if (cordic_start) begin
            m_it <= 0; m_lat <= cfg_lat; m_nd <= cfg_nd; m_a <= cordic_dataa;
         end else if (m_it < m_lat) begin
            m_it <= m_it + 1;
         end
      end
   end
   assign cordic_done   = !m_nd && (m_it == m_lat);
   assign cordic_result = cordic_done ? cos_ref(m_a) : (32'hBAD00000 | 32'(m_it));

   // Continuous checks: clock gating rule and head stability under backpressure.
   logic        pv = 1'b0, pr = 1'b0, pe = 1'b0;
   logic [31:0] pd = '0;
   always @(posedge clock) begin
      pv = out_valid && aclr_n; pr = out_ready; pd = out_data; pe = out_err;
   end
   always @(negedge clock) begin
      if (aclr_n) begin
         chk("clk_en_rule", cordic_clk_en, cordic_start | (busy & !cordic_done));
         if (pv && !pr) begin
            chk("hold_data", out_data, pd);
            chk("hold_err", out_err, pe);
         end
      end
   end

   task automatic run_one(input logic [31:0] a, input int lat, input bit nd,
                          output int n, output logic [31:0] d, output logic e);
      int w = 0;
      @(negedge clock);
      while (!in_ready && w < 50) begin @(negedge clock); w++; end
      chk("one_in_ready", in_ready, 1);
      cfg_lat = lat; cfg_nd = nd; in_valid = 1'b1; in_data = a;
      @(posedge clock); #1 in_valid = 1'b0;
      n = 0;
      do begin @(negedge clock); n++; end while (!out_valid && n < 40);
      d = out_data; e = out_err;
      out_ready = 1'b1;
      @(posedge clock); #1 out_ready = 1'b0;
   endtask

   typedef struct { logic [31:0] a; int lat; bit nd; } op_t;
   typedef struct { logic [31:0] d; logic e; } res_t;
   op_t  pend[$];
   res_t exp_q[$];
   int   hs_t[$];
   int   acc = 0, pops = 0, ref_errs = 0;

   // Per-cycle driver plus scoreboard; expectations come from the operation rules.
   task automatic run_stream(input int ncyc, input int p_in, input int p_out);
      op_t  o;
      res_t r;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         in_valid  = (pend.size() > 0) && ($urandom_range(99) < p_in);
         if (pend.size() > 0) in_data = pend[0].a;
         out_ready = ($urandom_range(99) < p_out);
         if (in_valid && in_ready) begin
            o = pend.pop_front();
            cfg_lat = o.lat; cfg_nd = o.nd;
            r.e = o.nd || (o.lat > TMO - 1);
            r.d = r.e ? 32'h0 : cos_ref(o.a);
            exp_q.push_back(r);
            ref_errs += int'(r.e);
            acc++;
            hs_t.push_back(c);
         end
         if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else begin
               r = exp_q.pop_front();
               chk("stream_data", out_data, r.d);
               chk("stream_err", out_err, r.e);
            end
         end
      end
      @(posedge clock); #1 in_valid = 1'b0; out_ready = 1'b0;
   endtask

   typedef struct { logic [31:0] a; int lat; bit nd; logic [31:0] xd; logic xe; int xn; } vec_t;
   vec_t tbl[8];

   initial begin
      int          n;
      logic [31:0] d;
      logic        e;
      op_t         o;

      tbl[0] = '{32'h3F800000,  4, 1'b0, 32'h3F0A5140, 1'b0,  7};
      tbl[1] = '{32'h00000000,  4, 1'b0, 32'h3F800000, 1'b0,  7};
      tbl[2] = '{32'h3F000000,  0, 1'b0, 32'h3F60A8B2, 1'b0,  3};
      tbl[3] = '{32'h3FC00000, 15, 1'b0, 32'h3D90DEAA, 1'b0, 18};
      tbl[4] = '{32'h12345678, 16, 1'b0, 32'h00000000, 1'b1, 18};
      tbl[5] = '{32'h40490FDB,  9, 1'b0, 32'hBF800000, 1'b0, 12};
      tbl[6] = '{32'hCAFEF00D,  0, 1'b1, 32'h00000000, 1'b1, 18};
      tbl[7] = '{32'h3F800000,  4, 1'b0, 32'h3F0A5140, 1'b0,  7};

      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clk_en", cordic_clk_en, 0);
      chk("rst_start", cordic_start, 0);
      chk("rst_dataa", cordic_dataa, 0);
      chk("rst_err_count", err_count, 0);
      aclr_n = 1'b1;
      @(negedge clock);
      chk("in_ready_after_rst", in_ready, 1);

      // Single operations: latency, value, error flag, timeout boundaries, stale done.
      foreach (tbl[i]) begin
         run_one(tbl[i].a, tbl[i].lat, tbl[i].nd, n, d, e);
         ref_errs += int'(tbl[i].xe);
         chk("tbl_latency", n, tbl[i].xn);
         chk("tbl_data", d, tbl[i].xd);
         chk("tbl_err", e, tbl[i].xe);
         chk("tbl_err_count", err_count, ref_errs);
      end

      // Back-to-back with the stream open: 7-cycle handshake spacing.
      hs_t.delete(); acc = 0; pops = 0;
      foreach (tbl[i]) if (i < 4) begin
         o = '{a: (i == 0) ? 32'h0 : (i == 1) ? 32'h3F000000 : (i == 2) ? 32'h3F800000 : 32'h3FC00000,
               lat: 4, nd: 1'b0};
         pend.push_back(o);
      end
      run_stream(45, 100, 100);
      chk("b2b_accepted", acc, 4);
      chk("b2b_popped", pops, 4);
      for (int i = 1; i < hs_t.size(); i++) chk("b2b_spacing", hs_t[i] - hs_t[i-1], 7);

      // Backpressure: only DEPTH requests fit while the sink stalls.
      acc = 0; pops = 0;
      for (int i = 0; i < 6; i++) begin
         o = '{a: 32'h40000000 + 32'(i), lat: 4, nd: 1'b0};
         pend.push_back(o);
      end
      run_stream(60, 100, 0);
      chk("bp_accepted", acc, DEPTH);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      run_stream(80, 100, 100);
      chk("bp_accepted_all", acc, 6);
      chk("bp_popped_all", pops, 6);
      chk("bp_queue_empty", exp_q.size(), 0);

      // Reset in cycle 4 of an operation, then a clean request.
      @(negedge clock);
      chk("rst_mid_ready", in_ready, 1);
      cfg_lat = 4; cfg_nd = 1'b0; in_valid = 1'b1; in_data = 32'h3F000000;
      @(posedge clock); #1 in_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("rst_mid_busy_before", busy, 1);
      aclr_n = 1'b0; #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_clk_en", cordic_clk_en, 0);
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_in_ready", in_ready, 0);
      chk("rst_mid_dataa", cordic_dataa, 0);
      @(negedge clock);
      chk("rst_mid_clk_en_held", cordic_clk_en, 0);
      aclr_n = 1'b1;
      ref_errs = 0;
      @(negedge clock);
      chk("rst_mid_ready_back", in_ready, 1);
      chk("rst_mid_fifo_empty", out_valid, 0);
      run_one(32'h3FC00000, 4, 1'b0, n, d, e);
      chk("post_rst_latency", n, 7);
      chk("post_rst_data", d, 32'h3D90DEAA);
      chk("post_rst_err", e, 0);
      @(negedge clock);
      chk("post_rst_drained", out_valid, 0);

      // Randomized traffic against the scoreboard.
      acc = 0; pops = 0;
      for (int i = 0; i < 80; i++) begin
         int sel = int'($urandom_range(99));
         o.a   = $urandom;
         o.nd  = (sel < 10);
         o.lat = (sel < 25) ? 15 + int'($urandom_range(1)) : int'($urandom_range(12));
         pend.push_back(o);
      end
      run_stream(1500, 70, 60);
      run_stream(800, 100, 100);
      chk("rnd_all_sent", pend.size(), 0);
      chk("rnd_all_popped", exp_q.size(), 0);
      chk("rnd_accept_pop", pops, acc);
      chk("rnd_err_count", err_count, ref_errs);

      // Error counter saturation.
      for (int i = 0; i < 270; i++) begin
         o = '{a: 32'(i), lat: 0, nd: 1'b1};
         pend.push_back(o);
      end
      run_stream(270 * 18 + 100, 100, 100);
      chk("sat_all_sent", pend.size(), 0);
      chk("sat_err_count", err_count, (ref_errs > 255) ? 255 : ref_errs);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
